// File: rtl/harmonic_scheduler.sv
// Per-sample harmonic sequencer for the additive oscillator: steps harmonics, drives lookup/multiplier/adders, latches and sends.
// Optional macro HARMONIC_SCHEDULER_OVERRUN_COUNT_EN builds a saturating overrun-tick counter on o_Overrun_Count.
module harmonic_scheduler #(
  parameter int NUM_HARMONICS   = 50,
  parameter int NUM_ADDERS      = 2,
  parameter int SAMPLE_INTERVAL = 1500,
  parameter int HARM_W          = 8
) (
  input  logic                  Main_Clock,
  input  logic                  Reset,
  input  logic [HARM_W-1:0]     i_Max_Harmonic,
  input  logic                  i_Freq_Too_High,
  input  logic                  i_Sample_Ready,
  output logic                  o_Next_Sample,
  output logic [HARM_W-1:0]     o_Harmonic,
  output logic                  o_Mult_Start,
  output logic                  o_Mult_Restart,
  input  logic                  i_Mult_Ready,
  input  logic                  i_Comb_Muted,
  output logic [NUM_ADDERS-1:0] o_Adder_Start,
  input  logic [NUM_ADDERS-1:0] i_Adder_Ready,
  output logic                  o_Adder_Clear,
  output logic                  o_Latch_Totals,
  output logic                  o_DAC_Send,
  output logic [HARM_W-1:0]     o_Harm_Count,
  output logic                  o_Overrun,
  output logic [15:0]           o_Overrun_Count
);

  localparam int TMR_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int SEL_W = (NUM_ADDERS > 1) ? $clog2(NUM_ADDERS) : 1;

  typedef enum logic [2:0] {ST_WAIT, ST_ADD, ST_NEXT, ST_MUTE, ST_DRAIN, ST_CLEAR} state_t;

  state_t              state, state_n;
  logic [TMR_W-1:0]    timer;
  logic [SEL_W-1:0]    sel, sel_n;
  logic [HARM_W-1:0]   limit, limit_n, count, count_n, harmonic_n, harm_count_n, max_clip;
  logic [NUM_ADDERS-1:0] adder_start_n;
  logic                next_sample_n, mult_start_n, mult_restart_n, adder_clear_n, latch_n, dac_n;
  logic                tick, overrun_tick;

  assign tick         = (timer == TMR_W'(SAMPLE_INTERVAL - 1));
  assign overrun_tick = tick && (state != ST_WAIT);
  assign max_clip     = (i_Max_Harmonic > HARM_W'(NUM_HARMONICS)) ? HARM_W'(NUM_HARMONICS) : i_Max_Harmonic;

  always_comb begin
    state_n        = state;
    sel_n          = sel;
    limit_n        = limit;
    count_n        = count;
    harmonic_n     = o_Harmonic;
    harm_count_n   = o_Harm_Count;
    next_sample_n  = 1'b0;
    mult_start_n   = 1'b0;
    mult_restart_n = 1'b0;
    adder_start_n  = '0;
    adder_clear_n  = 1'b0;
    latch_n        = 1'b0;
    dac_n          = 1'b0;
    case (state)
      ST_WAIT: if (tick) begin
        dac_n          = 1'b1;
        mult_restart_n = 1'b1;
        next_sample_n  = 1'b1;
        harmonic_n     = '0;
        sel_n          = '0;
        count_n        = '0;
        limit_n        = max_clip;
        state_n        = ST_ADD;
      end
      ST_ADD: if (i_Sample_Ready && i_Adder_Ready[sel]) begin
        adder_start_n = NUM_ADDERS'(1) << sel;
        count_n       = count + 1'b1;
        state_n       = ST_NEXT;
      end
      ST_NEXT: begin
        if ((o_Harmonic >= limit) || i_Freq_Too_High) begin
          state_n = ST_DRAIN;
        end else begin
          // sel tracks h mod NUM_ADDERS, so muted harmonics still advance it
          harmonic_n    = o_Harmonic + 1'b1;
          sel_n         = (sel == SEL_W'(NUM_ADDERS - 1)) ? '0 : sel + 1'b1;
          next_sample_n = 1'b1;
          mult_start_n  = 1'b1;
          state_n       = ST_MUTE;
        end
      end
      ST_MUTE: if (i_Mult_Ready) state_n = i_Comb_Muted ? ST_NEXT : ST_ADD;
      ST_DRAIN: if (&i_Adder_Ready) begin
        latch_n      = 1'b1;
        harm_count_n = count;
        state_n      = ST_CLEAR;
      end
      ST_CLEAR: begin
        adder_clear_n = 1'b1;
        state_n       = ST_WAIT;
      end
      default: state_n = ST_WAIT;
    endcase
  end

  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      state          <= ST_WAIT;
      timer          <= '0;
      sel            <= '0;
      limit          <= '0;
      count          <= '0;
      o_Harmonic     <= '0;
      o_Harm_Count   <= '0;
      o_Next_Sample  <= 1'b0;
      o_Mult_Start   <= 1'b0;
      o_Mult_Restart <= 1'b0;
      o_Adder_Start  <= '0;
      o_Adder_Clear  <= 1'b0;
      o_Latch_Totals <= 1'b0;
      o_DAC_Send     <= 1'b0;
      o_Overrun      <= 1'b0;
    end else begin
      state          <= state_n;
      timer          <= tick ? '0 : timer + 1'b1;
      sel            <= sel_n;
      limit          <= limit_n;
      count          <= count_n;
      o_Harmonic     <= harmonic_n;
      o_Harm_Count   <= harm_count_n;
      o_Next_Sample  <= next_sample_n;
      o_Mult_Start   <= mult_start_n;
      o_Mult_Restart <= mult_restart_n;
      o_Adder_Start  <= adder_start_n;
      o_Adder_Clear  <= adder_clear_n;
      o_Latch_Totals <= latch_n;
      o_DAC_Send     <= dac_n;
      if (overrun_tick) o_Overrun <= 1'b1;
    end
  end

`ifdef HARMONIC_SCHEDULER_OVERRUN_COUNT_EN
  logic [15:0] overrun_cnt;
  always_ff @(posedge Main_Clock) begin
    if (Reset) overrun_cnt <= '0;
    else if (overrun_tick && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + 1'b1;
  end
  assign o_Overrun_Count = overrun_cnt;
`else
  assign o_Overrun_Count = '0;
`endif

endmodule

// File: doc/harmonic_scheduler.md
Name: harmonic_scheduler

Overview:
- Parametrised frame sequencer for the additive oscillator.
- Once per audio sample it steps the harmonic index from 0 to a runtime limit, and handshakes with the sample-position lookup, the scale multiplier and NUM_ADDERS round-robin accumulators.
- It then latches the totals, clears the accumulators and fires the DAC send on the sample tick.
- Generalises the fixed two-adder, fixed-count sequencing with a runtime harmonic limit, N adders, muted-harmonic skipping and overrun detection.

Parameters:
- NUM_HARMONICS, 50, hard ceiling on harmonic index (inclusive).
- NUM_ADDERS, 2, number of accumulators (1..8); harmonic h goes to adder h mod NUM_ADDERS.
- SAMPLE_INTERVAL, 1500, Main_Clock cycles per output sample (72 MHz / 48 kHz).
- HARM_W, 8, harmonic index width.

Ports:
- Main_Clock  in  1  system clock
- Reset  in  1  synchronous active-high reset
- i_Max_Harmonic  in  HARM_W  runtime limit; effective limit = min(i_Max_Harmonic, NUM_HARMONICS)
- i_Freq_Too_High  in  1  current harmonic above Nyquist; ends frame
- i_Sample_Ready  in  1  lookup value valid for o_Harmonic
- o_Next_Sample  out  1  one-cycle pulse requesting lookup of the new o_Harmonic
- o_Harmonic  out  HARM_W  current harmonic index
- o_Mult_Start  out  1  one-cycle pulse to step the scale multiplier
- o_Mult_Restart  out  1  one-cycle pulse at frame start to reload the initial scale
- i_Mult_Ready  in  1  multiplier result and comb mute valid
- i_Comb_Muted  in  1  current harmonic muted; skip accumulation
- o_Adder_Start  out  NUM_ADDERS  one-hot one-cycle start to the selected adder
- i_Adder_Ready  in  NUM_ADDERS  per-adder idle
- o_Adder_Clear  out  1  one-cycle accumulator clear
- o_Latch_Totals  out  1  one-cycle pulse: parent registers adder totals
- o_DAC_Send  out  1  one-cycle pulse aligned to sample tick
- o_Harm_Count  out  HARM_W  number of harmonics accumulated in the last completed frame
- o_Overrun  out  1  sticky: a tick arrived before the frame completed
- o_Overrun_Count  out  16  see Optional Feature

Behaviour:
- Reset clears every output, the timer and the adder-select counter to 0; state = ST_WAIT.
- Reset mid-frame abandons the frame with no pulses.
- Sample timer: free-running, counts 0..SAMPLE_INTERVAL-1. Tick = timer at SAMPLE_INTERVAL-1; it then wraps to 0.
- Adder select: separate modulo-NUM_ADDERS counter, reset to 0 each frame, incremented on every harmonic step including muted ones. It therefore always equals h mod NUM_ADDERS; no power-of-2 requirement.
- ST_WAIT (frame completed): on tick, pulse o_DAC_Send, o_Mult_Restart and o_Next_Sample; set o_Harmonic = 0; go to ST_ADD.
- ST_ADD: wait for i_Sample_Ready && i_Adder_Ready[sel], then pulse o_Adder_Start[sel], increment the accumulated count, go to ST_NEXT.
- ST_NEXT:
  - If o_Harmonic >= limit or i_Freq_Too_High, go to ST_DRAIN.
  - Otherwise increment o_Harmonic and sel, pulse o_Next_Sample and o_Mult_Start, go to ST_MUTE.
- ST_MUTE: wait for i_Mult_Ready; if i_Comb_Muted go to ST_NEXT, else ST_ADD. Harmonic 0 is never muted.
- ST_DRAIN: wait until all i_Adder_Ready are high; pulse o_Latch_Totals, load o_Harm_Count, go to ST_CLEAR.
- ST_CLEAR: pulse o_Adder_Clear for 1 cycle, go to ST_WAIT.
- Latency: tick to first o_Adder_Start is ≥1 cycle after i_Sample_Ready. Latch to clear is 1 cycle.
- Overrun: a tick in any state other than ST_WAIT sets o_Overrun (cleared only by Reset). No o_DAC_Send is issued for that tick; the frame continues and its result is sent on the next tick.
- Tick in the same cycle as the ST_CLEAR→ST_WAIT transition counts as overrun; the send waits for the next tick.
- i_Max_Harmonic is sampled at frame start only.

Optional Feature:
- Macro HARMONIC_SCHEDULER_OVERRUN_COUNT_EN.
- Defined: o_Overrun_Count is a 16-bit counter of overrun ticks, saturating at 0xFFFF, cleared by Reset.
- Undefined: no counter logic is built; o_Overrun_Count is tied to 0. o_Overrun behaves the same either way.

Test Plan:
- Limit 3, NUM_ADDERS=2, ready inputs held high, no mutes → o_Adder_Start sequence 01,10,01,10 for h=0..3; o_Harm_Count=4; one o_Latch_Totals, then o_Adder_Clear the next cycle; o_DAC_Send at the next tick.
- Limit 5, i_Comb_Muted high for h=2,4 → starts only for h=0,1,3,5 with one-hot 001,010,001,100 (NUM_ADDERS=3); o_Harm_Count=4.
- i_Freq_Too_High asserted at h=7, limit 50 → frame ends after h=7 is accumulated; o_Harm_Count=8.
- i_Max_Harmonic=200 with NUM_HARMONICS=50 → last harmonic accumulated is 50; o_Harm_Count=51.
- SAMPLE_INTERVAL=20, i_Adder_Ready held low 30 cycles → o_Overrun=1 and no o_DAC_Send at the missed tick; send at the following tick. With the macro defined, o_Overrun_Count=1.
- Reset asserted while in ST_MUTE → all outputs 0 next cycle; the first o_DAC_Send comes at the first tick after release.
